// File: rtl/parser_input_arbiter.sv
// Packet-atomic round-robin arbiter feeding the sequence parser's single word-stream input.
// Holds a grant for a whole packet, truncates and drains packets longer than MAX_WORDS.
module parser_input_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int MAX_WORDS = 12,
    localparam int GW = $clog2(NUM_SRC),
    localparam int CW = $clog2(MAX_WORDS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [32*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]      src_val,
    input  logic [NUM_SRC-1:0]      src_last,
    output logic [NUM_SRC-1:0]      src_ready,
    output logic [31:0]             dataOut,
    output logic                    dataOut_val,
    output logic                    dataOut_last,
    input  logic                    dataOut_ready,
    output logic [GW-1:0]           grant_id,
    output logic                    busy,
    output logic                    err_truncated
);

    typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

    state_t        state, nextState;
    logic [GW-1:0] rrPtr, nextRrPtr, nextGrant, rrWinner, grantPlusOne;
    logic [CW-1:0] wordCnt, nextWordCnt;
    logic          nextErr;
    logic          grantVal, grantLast, forcedLast;
    logic [31:0]   grantData;

    assign grantVal   = src_val[grant_id];
    assign grantLast  = src_last[grant_id];
    assign grantData  = src_data[32*grant_id +: 32];
    assign forcedLast = (wordCnt == CW'(MAX_WORDS - 1));

    // Wrap is mod NUM_SRC, so non-power-of-two source counts never load an unused id.
    assign grantPlusOne = (grant_id == GW'(NUM_SRC - 1)) ? '0 : grant_id + GW'(1);

    // Lowest requester at or above rrPtr wins; otherwise the lowest requester overall.
    always_comb begin
        rrWinner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (src_val[i]) rrWinner = GW'(i);
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (src_val[i] && i >= int'(rrPtr)) rrWinner = GW'(i);
    end

    // NOTE: every signal gets a default before the case so no path leaves a latch behind.
    always_comb begin
        nextState    = state;
        nextGrant    = grant_id;
        nextRrPtr    = rrPtr;
        nextWordCnt  = wordCnt;
        nextErr      = 1'b0;
        src_ready    = '0;
        dataOut      = '0;
        dataOut_val  = 1'b0;
        dataOut_last = 1'b0;
        busy         = 1'b0;

        case (state)
            IDLE: begin
                if (|src_val) begin
                    nextGrant   = rrWinner;
                    nextWordCnt = '0;
                    nextState   = PASS;
                end
            end
            PASS: begin
                busy                = 1'b1;
                dataOut_val         = grantVal;
                dataOut             = grantVal ? grantData : '0;
                dataOut_last        = grantVal & (grantLast | forcedLast);
                src_ready[grant_id] = dataOut_ready;
                if (grantVal && dataOut_ready) begin
                    nextWordCnt = wordCnt + CW'(1);
                    if (grantLast) begin
                        nextState = IDLE;
                        nextRrPtr = grantPlusOne;
                    end else if (forcedLast) begin
                        nextState = DRAIN;
                        nextErr   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Swallow the oversize tail until the source presents its real last word.
                busy                = 1'b1;
                src_ready[grant_id] = 1'b1;
                if (grantVal && grantLast) begin
                    nextState = IDLE;
                    nextRrPtr = grantPlusOne;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant_id      <= '0;
            rrPtr         <= '0;
            wordCnt       <= '0;
            err_truncated <= 1'b0;
        end else begin
            state         <= nextState;
            grant_id      <= nextGrant;
            rrPtr         <= nextRrPtr;
            wordCnt       <= nextWordCnt;
            err_truncated <= nextErr;
        end
    end

endmodule

// File: tb/tb_parser_input_arbiter.sv
// Scoreboard bench for parser_input_arbiter: random packet sources and parser backpressure,
// checked against a packet-level model of round-robin order, truncation and drain.
module tb_parser_input_arbiter;

    localparam int N    = 4;
    localparam int MAXW = 12;
    localparam int GW   = 2;
    localparam int PKTS = 30;

    logic              clk = 1'b0;
    logic              reset;
    logic [32*N-1:0]   src_data;
    logic [N-1:0]      src_val, src_last, src_ready;
    logic [31:0]       dataOut;
    logic              dataOut_val, dataOut_last, dataOut_ready;
    logic [GW-1:0]     grant_id;
    logic              busy, err_truncated;

    parser_input_arbiter #(.NUM_SRC(N), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset),
        .src_data(src_data), .src_val(src_val), .src_last(src_last), .src_ready(src_ready),
        .dataOut(dataOut), .dataOut_val(dataOut_val), .dataOut_last(dataOut_last),
        .dataOut_ready(dataOut_ready),
        .grant_id(grant_id), .busy(busy), .err_truncated(err_truncated)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        trunc;
    } exp_t;

    exp_t expQ[N][$];
    int   nVec = 0, nMis = 0;
    bit   stop = 1'b0;

    int len[N], idx[N], pktNum[N], issued[N];
    bit active[N];
    bit mIdle = 1'b1, mDrop = 1'b0, errNext = 1'b0;
    int mWinner = 0, mRr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wordOf(input int s, input int p, input int w);
        return {4'(s), 12'(p), 16'(w)};
    endfunction

    // Issuing a packet pushes the words the parser must see: at most MAXW, last one flagged.
    task automatic newPacket(input int i);
        int r, fwd;
        r = $urandom_range(0, 7);
        case (r)
            0:       len[i] = MAXW;
            1:       len[i] = $urandom_range(MAXW + 1, MAXW + 4);
            2:       len[i] = MAXW - 1;
            default: len[i] = $urandom_range(1, 6);
        endcase
        idx[i] = 0;
        pktNum[i]++;
        issued[i]++;
        active[i] = 1'b1;
        fwd = (len[i] > MAXW) ? MAXW : len[i];
        for (int w = 0; w < fwd; w++) begin
            exp_t e;
            e.data  = wordOf(i, pktNum[i], w);
            e.last  = (w == fwd - 1);
            e.trunc = (w == fwd - 1) && (len[i] > MAXW);
            expQ[i].push_back(e);
        end
    endtask

    task automatic driver();
        bit xf[N];
        while (!stop) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) xf[i] = src_val[i] & src_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (xf[i]) begin
                    idx[i]++;
                    if (idx[i] == len[i]) active[i] = 1'b0;
                    src_val[i] = 1'b0;
                end
                if (!src_val[i]) begin
                    if (!active[i] && issued[i] < PKTS && $urandom_range(0, 2) == 0) newPacket(i);
                    if (active[i]) begin
                        src_val[i]          = ($urandom_range(0, 3) != 0);
                        src_data[32*i +: 32] = wordOf(i, pktNum[i], idx[i]);
                        src_last[i]         = (idx[i] == len[i] - 1);
                    end else begin
                        src_data[32*i +: 32] = '0;
                        src_last[i]         = 1'b0;
                    end
                end
            end
            dataOut_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic monitor();
        exp_t e;
        int   w;
        while (!stop) begin
            @(negedge clk);
            check("err_truncated", err_truncated, errNext);
            errNext = 1'b0;
            check("busy", busy, !mIdle);
            if (mIdle) begin
                check("idle_val", dataOut_val, 0);
                check("idle_ready", src_ready, 0);
                if (|src_val) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (src_val[(mRr + k) % N]) mWinner = (mRr + k) % N;
                    mIdle = 1'b0;
                    mDrop = 1'b0;
                end
            end else begin
                w = mWinner;
                check("grant_id", grant_id, w);
                check("other_ready", src_ready & ~(N'(1) << w), 0);
                if (mDrop) begin
                    check("drain_val", dataOut_val, 0);
                    check("drain_ready", src_ready[w], 1);
                    if (src_val[w] && src_last[w]) begin
                        mIdle = 1'b1;
                        mRr   = (w + 1) % N;
                    end
                end else begin
                    check("ready_mirror", src_ready[w], dataOut_ready);
                    check("pass_val", dataOut_val, src_val[w]);
                    if (!dataOut_val) check("idle_data", dataOut, 0);
                    if (dataOut_val && dataOut_ready) begin
                        if (expQ[w].size() == 0) begin
                            check("unexpected_word", dataOut, 32'hDEAD_BEEF);
                        end else begin
                            e = expQ[w].pop_front();
                            check("data", dataOut, e.data);
                            check("last", dataOut_last, e.last);
                            if (e.trunc) begin
                                errNext = 1'b1;
                                mDrop   = 1'b1;
                            end
                        end
                        if (src_last[w]) begin
                            mIdle = 1'b1;
                            mRr   = (w + 1) % N;
                        end
                    end
                end
            end
        end
    endtask

    function automatic bit allDone();
        for (int i = 0; i < N; i++)
            if (issued[i] < PKTS || active[i] || expQ[i].size() != 0) return 1'b0;
        return mIdle && (src_val == '0);
    endfunction

    initial begin
        int cyc;
        reset = 1'b1; src_val = '0; src_last = '0; src_data = '0; dataOut_ready = 1'b0;
        #1;
        check("rst_val", dataOut_val, 0);
        check("rst_data", dataOut, 0);
        check("rst_last", dataOut_last, 0);
        check("rst_ready", src_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_truncated, 0);
        check("rst_grant", grant_id, 0);

        // Source 0 one-word packet, then source 1 aborted mid-packet by reset.
        tick();
        reset = 1'b0; src_val = 4'b0001; src_data[31:0] = 32'hA1; src_last = 4'b0001; dataOut_ready = 1'b1;
        #2;
        check("arb_no_consume", src_ready, 0);
        check("arb_busy", busy, 0);
        tick(); #2;
        check("d_grant0", grant_id, 0);
        check("d_data_a1", dataOut, 32'hA1);
        check("d_last_a1", dataOut_last, 1);
        check("d_ready0", src_ready, 4'b0001);
        tick();
        src_val = 4'b0010; src_last = '0; src_data[63:32] = 32'hB1;
        #2;
        check("d_gap", busy, 0);
        tick(); #2;
        check("d_grant1", grant_id, 1);
        check("d_data_b1", dataOut, 32'hB1);
        tick();
        src_data[63:32] = 32'hB2;
        #2;
        check("d_data_b2", dataOut, 32'hB2);
        reset = 1'b1;
        #1;
        check("abort_val", dataOut_val, 0);
        check("abort_data", dataOut, 0);
        check("abort_ready", src_ready, 0);
        check("abort_busy", busy, 0);
        tick();
        reset = 1'b0; src_val = 4'b0011; src_data[31:0] = 32'hC1; src_last = 4'b0001;
        tick(); #2;
        check("tie_grant0", grant_id, 0);
        check("tie_data", dataOut, 32'hC1);

        // Clean restart for the randomized scoreboard phase.
        src_val = '0; src_last = '0; src_data = '0; reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            len[i] = 0; idx[i] = 0; pktNum[i] = 0; issued[i] = 0; active[i] = 1'b0;
        end
        fork
            driver();
            monitor();
        join_none

        cyc = 0;
        while (cyc < 30000 && !allDone()) begin
            @(posedge clk);
            cyc++;
        end
        if (!allDone()) check("timeout", 1, 0);
        stop = 1'b1;
        repeat (3) @(posedge clk);
        for (int i = 0; i < N; i++) check("leftover_words", expQ[i].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
